// File: rtl/dpram_be_sc.sv
// dpram_be_sc: single-clock true dual-port RAM with byte enables, write-first forwarding and init sweep
module dpram_be_sc #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8,
  parameter int BEWIDTH = DWIDTH / 8,
  parameter int RD_LAT = 1,
  parameter logic [DWIDTH-1:0] INIT_VALUE = '0,
  parameter bit INIT_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  output logic              ready,
  output logic              coll,
  input  logic              rea,
  input  logic              wea,
  input  logic [AWIDTH-1:0] addra,
  input  logic [DWIDTH-1:0] dataa,
  input  logic [BEWIDTH-1:0] bea,
  output logic [DWIDTH-1:0] qa,
  output logic              qa_vld,
  input  logic              reb,
  input  logic              web,
  input  logic [AWIDTH-1:0] addrb,
  input  logic [DWIDTH-1:0] datab,
  input  logic [BEWIDTH-1:0] beb,
  output logic [DWIDTH-1:0] qb,
  output logic              qb_vld
);
  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [0:0] S_RUN = 1'b0;
  localparam logic [0:0] S_INIT = 1'b1;

  if (DWIDTH % 8 != 0 || BEWIDTH != DWIDTH / 8) begin : g_bad_dw
    $error("dpram_be_sc: DWIDTH must be a multiple of 8 and BEWIDTH must equal DWIDTH/8");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("dpram_be_sc: RD_LAT must be 1 or 2");
  end

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [0:0] state;
  logic [AWIDTH-1:0] cnt;
  logic run, ra, rb, va1, vb1;
  logic [BEWIDTH-1:0] wa_be, wb_be;
  logic [DWIDTH-1:0] fa, fb, da1, db1;

  assign run = state == S_RUN;
  assign ready = rst_n && run;
  assign ra = run && rea;
  assign rb = run && reb;
  assign wa_be = (run && wea) ? bea : '0;
  assign wb_be = (run && web) ? beb : '0;

  // Read data as the array will look after this cycle's writes; port A wins overlapping bytes.
  always_comb begin
    fa = mem[addra];
    fb = mem[addrb];
    for (int i = 0; i < BEWIDTH; i++) begin
      if (wb_be[i]) begin
        fb[8*i+:8] = datab[8*i+:8];
        if (addra == addrb) fa[8*i+:8] = datab[8*i+:8];
      end
      if (wa_be[i]) begin
        fa[8*i+:8] = dataa[8*i+:8];
        if (addra == addrb) fb[8*i+:8] = dataa[8*i+:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !run) mem[cnt] <= INIT_VALUE;
    for (int i = 0; i < BEWIDTH; i++) begin
      if (wb_be[i]) mem[addrb][8*i+:8] <= datab[8*i+:8];
      if (wa_be[i]) mem[addra][8*i+:8] <= dataa[8*i+:8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT_ON_RST ? S_INIT : S_RUN;
      cnt <= '0;
      coll <= 1'b0;
    end else begin
      state <= run ? (init_req ? S_INIT : S_RUN) : (&cnt ? S_RUN : S_INIT);
      cnt <= run ? '0 : cnt + AWIDTH'(1);
      coll <= |(wa_be & wb_be) && addra == addrb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va1 <= 1'b0;
      vb1 <= 1'b0;
      da1 <= '0;
      db1 <= '0;
    end else begin
      va1 <= ra;
      vb1 <= rb;
      if (ra) da1 <= fa;
      if (rb) db1 <= fb;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        qa_vld <= 1'b0;
        qb_vld <= 1'b0;
        qa <= '0;
        qb <= '0;
      end else begin
        qa_vld <= va1;
        qb_vld <= vb1;
        if (va1) qa <= da1;
        if (vb1) qb <= db1;
      end
    end
  end else begin : g_lat1
    assign qa_vld = va1;
    assign qb_vld = vb1;
    assign qa = da1;
    assign qb = db1;
  end
endmodule

// File: tb/tb_dpram_be_sc.sv
// tb_dpram_be_sc: scoreboard bench running RD_LAT=1 and RD_LAT=2 instances on shared stimulus
module tb_dpram_be_sc;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam logic [15:0] IV = 16'hA5A5;

  logic clk = 1'b0, rst_n = 1'b0, init_req = 1'b0;
  logic rea = 1'b0, wea = 1'b0, reb = 1'b0, web = 1'b0;
  logic [AW-1:0] addra = '0, addrb = '0;
  logic [15:0] dataa = '0, datab = '0;
  logic [1:0] bea = '0, beb = '0;
  logic rdy1, rdy2, coll1, coll2, qav1, qbv1, qav2, qbv2;
  logic [15:0] qa1, qb1, qa2, qb2;

  dpram_be_sc #(.DWIDTH(16), .AWIDTH(AW), .RD_LAT(1), .INIT_VALUE(IV), .INIT_ON_RST(1'b1)) d1 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .ready(rdy1), .coll(coll1),
    .rea(rea), .wea(wea), .addra(addra), .dataa(dataa), .bea(bea), .qa(qa1), .qa_vld(qav1),
    .reb(reb), .web(web), .addrb(addrb), .datab(datab), .beb(beb), .qb(qb1), .qb_vld(qbv1));

  dpram_be_sc #(.DWIDTH(16), .AWIDTH(AW), .RD_LAT(2), .INIT_VALUE(IV), .INIT_ON_RST(1'b1)) d2 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .ready(rdy2), .coll(coll2),
    .rea(rea), .wea(wea), .addra(addra), .dataa(dataa), .bea(bea), .qa(qa2), .qa_vld(qav2),
    .reb(reb), .web(web), .addrb(addrb), .datab(datab), .beb(beb), .qb(qb2), .qb_vld(qbv2));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    int e;
  } ent_t;

  ent_t la[$], lb[$];
  logic [15:0] mem [DEPTH];
  int init_left = 0, cyc = 0, checks = 0, failures = 0;
  int ptr [2][2];
  logic [15:0] last [2][2];
  logic exp_ready = 1'b0, exp_coll = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic check_port(input int k, input int p, input logic v, input logic [15:0] q);
    ent_t e;
    int sz;
    sz = p ? lb.size() : la.size();
    e = '0;
    if (ptr[k][p] < sz) e = p ? lb[ptr[k][p]] : la[ptr[k][p]];
    if (v) begin
      if (ptr[k][p] >= sz) begin
        checks++;
        failures++;
        $display("FAIL unexpected_vld lat%0d port%0d cyc=%0d got=1 want=0", k + 1, p, cyc);
      end else begin
        chk($sformatf("q_data_lat%0d_port%0d", k + 1, p), 32'(q), 32'(e.d));
        chk($sformatf("q_cycle_lat%0d_port%0d", k + 1, p), cyc, e.e + k);
        last[k][p] = e.d;
        ptr[k][p]++;
      end
    end else begin
      chk($sformatf("q_hold_lat%0d_port%0d", k + 1, p), 32'(q), 32'(last[k][p]));
      if (ptr[k][p] < sz && e.e + k <= cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_vld lat%0d port%0d cyc=%0d got=0 want=1", k + 1, p, cyc);
        ptr[k][p]++;
      end
    end
  endtask

  // Monitor: compares every cycle against the expectations the driver left for that edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    chk("ready_lat1", 32'(rdy1), 32'(exp_ready));
    chk("ready_lat2", 32'(rdy2), 32'(exp_ready));
    chk("coll_lat1", 32'(coll1), 32'(exp_coll));
    chk("coll_lat2", 32'(coll2), 32'(exp_coll));
    check_port(0, 0, qav1, qa1);
    check_port(0, 1, qbv1, qb1);
    check_port(1, 0, qav2, qa2);
    check_port(1, 1, qbv2, qb2);
  end

  // Reference model of one clock edge using the inputs currently driven.
  task automatic tick();
    int e;
    e = cyc + 1;
    exp_coll = 1'b0;
    if (init_left > 0) begin
      mem[DEPTH-init_left] = IV;
      init_left--;
    end else begin
      exp_coll = wea && web && addra == addrb && (bea & beb) != 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (web && beb[i]) mem[addrb][8*i+:8] = datab[8*i+:8];
        if (wea && bea[i]) mem[addra][8*i+:8] = dataa[8*i+:8];
      end
      if (rea) la.push_back(ent_t'{mem[addra], e});
      if (reb) lb.push_back(ent_t'{mem[addrb], e});
      if (init_req) init_left = DEPTH;
    end
    exp_ready = init_left == 0;
    @(negedge clk);
  endtask

  task automatic idle();
    rea = 1'b0; wea = 1'b0; reb = 1'b0; web = 1'b0; init_req = 1'b0;
  endtask

  task automatic rnd();
    rea = 1'($urandom); wea = 1'($urandom); reb = 1'($urandom); web = 1'($urandom);
    addra = AW'($urandom_range(0, DEPTH - 1));
    addrb = ($urandom_range(0, 3) == 0) ? addra : AW'($urandom_range(0, DEPTH - 1));
    dataa = 16'($urandom); datab = 16'($urandom);
    bea = 2'($urandom); beb = 2'($urandom);
  endtask

  task automatic flush();
    for (int k = 0; k < 2; k++) begin
      ptr[k][0] = la.size();
      ptr[k][1] = lb.size();
      last[k][0] = '0;
      last[k][1] = '0;
    end
    init_left = DEPTH;
    exp_coll = 1'b0;
    exp_ready = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      rea = 1'b1; reb = 1'b1;
      addra = AW'(i); addrb = AW'(DEPTH - 1 - i);
      tick();
    end
    idle();
  endtask

  initial begin
    flush();
    @(negedge clk);
    chk("rst_qa", 32'(qa1), 0);
    chk("rst_qb", 32'(qb2), 0);
    chk("rst_qa_vld", 32'(qav2), 0);
    chk("rst_qb_vld", 32'(qbv1), 0);
    chk("rst_coll", 32'(coll1), 0);
    chk("rst_ready", 32'(rdy1), 0);
    rst_n = 1'b1;
    repeat (DEPTH) tick();
    chk("ready_after_sweep", 32'(rdy2), 1);
    read_all();
    wea = 1'b1; addra = 4'd3; dataa = 16'hBEEF; bea = 2'b11;
    tick();
    idle(); rea = 1'b1;
    tick();
    idle(); repeat (3) tick();
    wea = 1'b1; addra = 4'd7; bea = 2'b11; dataa = 16'h1234;
    web = 1'b1; addrb = 4'd7; beb = 2'b01; datab = 16'h00FF;
    tick();
    idle(); rea = 1'b1; tick();
    idle(); wea = 1'b1; bea = 2'b01; web = 1'b1; beb = 2'b10;
    tick();
    idle(); rea = 1'b1; tick();
    idle(); wea = 1'b1; addra = 4'd5; bea = 2'b11; dataa = 16'h1111;
    tick();
    bea = 2'b01; dataa = 16'hAAAA; reb = 1'b1; addrb = 4'd5;
    tick();
    idle(); tick();
    for (int i = 0; i < 32; i++) begin
      rnd();
      rea = 1'b1; reb = 1'b1;
      tick();
    end
    idle(); rea = 1'b1; addra = 4'd2; init_req = 1'b1; wea = 1'b1; dataa = 16'h5A5A; bea = 2'b10;
    tick();
    init_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rnd();
      tick();
    end
    idle(); tick();
    read_all();
    rea = 1'b1; reb = 1'b1; addra = 4'd9; addrb = 4'd9; init_req = 1'b1;
    tick();
    init_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rnd();
      tick();
    end
    idle();
    rst_n = 1'b0;
    flush();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rnd();
      tick();
    end
    chk("ready_after_restart", 32'(rdy1), 1);
    idle();
    read_all();
    repeat (4) tick();
    chk("drain_lat1_a", ptr[0][0], la.size());
    chk("drain_lat1_b", ptr[0][1], lb.size());
    chk("drain_lat2_a", ptr[1][0], la.size());
    chk("drain_lat2_b", ptr[1][1], lb.size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
